// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer for the pipelined FPU: latches one FP instruction, holds the FPU inputs
// for the op's fixed latency, then offers the captured result to writeback.
module fpu_issue_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RD_W       = 5,
    parameter int unsigned LAT_ADDSUB = 7,
    parameter int unsigned LAT_MUL    = 5,
    parameter int unsigned LAT_DIV    = 6,
    parameter int unsigned LAT_SGNJ   = 0,
    parameter int unsigned LAT_MINMAX = 1,
    parameter int unsigned LAT_SQRT   = 16,
    parameter int unsigned LAT_CMP    = 1,
    parameter int unsigned LAT_CVT    = 6
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             flush,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [3:0]       issue_op,
    input  logic [2:0]       issue_func3,
    input  logic             issue_rs1_0,
    input  logic [WIDTH-1:0] issue_a,
    input  logic [WIDTH-1:0] issue_b,
    input  logic [RD_W-1:0]  issue_rd,
    output logic             fpu_sel,
    output logic [3:0]       fpu_op,
    output logic [2:0]       fpu_func3,
    output logic             fpu_rs1_0,
    output logic [WIDTH-1:0] fpu_dataA,
    output logic [WIDTH-1:0] fpu_dataB,
    input  logic [WIDTH-1:0] fpu_result,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [WIDTH-1:0] wb_data,
    output logic [RD_W-1:0]  wb_rd,
    output logic             wb_to_int,
    output logic             wb_illegal,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [2:0]       func3_q, func3_d;
    logic             rs1_0_q, rs1_0_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [RD_W-1:0]  rd_q, rd_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             illegal_q, illegal_d;
    logic             to_int_q, to_int_d;
    logic             accept;
    logic             legal;

    function automatic logic [4:0] lat_of(input logic [3:0] op);
        logic [4:0] lat;
        lat = 5'd0;
        case (op)
            4'h0, 4'h1: lat = 5'(LAT_ADDSUB);
            4'h2:       lat = 5'(LAT_MUL);
            4'h3:       lat = 5'(LAT_DIV);
            4'h4:       lat = 5'(LAT_SGNJ);
            4'h5:       lat = 5'(LAT_MINMAX);
            4'h6:       lat = 5'(LAT_SQRT);
            4'h7:       lat = 5'(LAT_CMP);
            4'h8, 4'h9: lat = 5'(LAT_CVT);
            default:    lat = 5'd0;
        endcase
        return lat;
    endfunction

    assign issue_ready = (state_q == StIdle) | ((state_q == StDone) & wb_ready);
    assign accept      = issue_valid & issue_ready & ~flush;
    assign legal       = (issue_op <= 4'd9);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        func3_d   = func3_q;
        rs1_0_d   = rs1_0_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_d      = rd_q;
        data_d    = data_q;
        illegal_d = illegal_q;
        to_int_d  = to_int_q;

        case (state_q)
            StIdle: ;
            StBusy: begin
                if (cnt_q == lat_of(op_q)) begin
                    data_d  = fpu_result;
                    state_d = StDone;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StDone: begin
                if (wb_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // An accept in DONE overrides the return to IDLE for zero-bubble back-to-back issue.
        if (accept) begin
            op_d    = issue_op;
            func3_d = issue_func3;
            rs1_0_d = issue_rs1_0;
            a_d     = issue_a;
            b_d     = issue_b;
            rd_d    = issue_rd;
            cnt_d   = 5'd0;
            if (legal) begin
                state_d   = StBusy;
                illegal_d = 1'b0;
                to_int_d  = (issue_op == 4'h7) | (issue_op == 4'h8);
            end else begin
                state_d   = StDone;
                data_d    = '0;
                illegal_d = 1'b1;
                to_int_d  = 1'b0;
            end
        end

        if (flush) begin
            state_d = StIdle;
            cnt_d   = 5'd0;
            data_d  = data_q;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            op_q      <= 4'd0;
            func3_q   <= 3'd0;
            rs1_0_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            data_q    <= '0;
            illegal_q <= 1'b0;
            to_int_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            func3_q   <= func3_d;
            rs1_0_q   <= rs1_0_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            illegal_q <= illegal_d;
            to_int_q  <= to_int_d;
        end
    end

    assign fpu_sel    = (state_q == StBusy);
    assign wb_valid   = (state_q == StDone);
    assign busy       = (state_q != StIdle);
    assign fpu_op     = op_q;
    assign fpu_func3  = func3_q;
    assign fpu_rs1_0  = rs1_0_q;
    assign fpu_dataA  = a_q;
    assign fpu_dataB  = b_q;
    assign wb_data    = data_q;
    assign wb_rd      = rd_q;
    assign wb_to_int  = to_int_q;
    assign wb_illegal = illegal_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl; the FPU stand-in only drives the expected result
// in the final fpu_sel cycle, so a capture on the wrong cycle is visible.
module tb_fpu_issue_ctrl;

    logic        clock = 1'b0;
    logic        clear, flush, issue_valid, issue_ready;
    logic [3:0]  issue_op, fpu_op;
    logic [2:0]  issue_func3, fpu_func3;
    logic        issue_rs1_0, fpu_rs1_0, fpu_sel;
    logic [31:0] issue_a, issue_b, fpu_dataA, fpu_dataB, fpu_result, wb_data;
    logic [4:0]  issue_rd, wb_rd;
    logic        wb_valid, wb_ready, wb_to_int, wb_illegal, busy;

    int          n_checks = 0;
    int          n_fail = 0;
    int          sel_run = 0;
    int          lat_exp = 0;
    logic [31:0] res_val = 32'h0;
    int          sel_cnt, wv_cyc;

    always #5 clock = ~clock;

    always @(posedge clock) sel_run <= fpu_sel ? sel_run + 1 : 0;
    assign fpu_result = (fpu_sel && sel_run == lat_exp) ? res_val : 32'hBAD0BAD0;

    fpu_issue_ctrl dut (
        .clock(clock), .clear(clear), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_func3(issue_func3), .issue_rs1_0(issue_rs1_0), .issue_a(issue_a),
        .issue_b(issue_b), .issue_rd(issue_rd),
        .fpu_sel(fpu_sel), .fpu_op(fpu_op), .fpu_func3(fpu_func3), .fpu_rs1_0(fpu_rs1_0),
        .fpu_dataA(fpu_dataA), .fpu_dataB(fpu_dataB), .fpu_result(fpu_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_to_int(wb_to_int), .wb_illegal(wb_illegal), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Presents one instruction for a single cycle; returns in cycle 1 after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int lat, input logic [31:0] res);
        lat_exp     = lat;
        res_val     = res;
        issue_valid = 1'b1;
        issue_op    = op;
        issue_func3 = 3'd1;
        issue_rs1_0 = 1'b1;
        issue_a     = a;
        issue_b     = b;
        issue_rd    = rd;
        tick();
        issue_valid = 1'b0;
    endtask

    // Counts fpu_sel cycles and the cycle (1 = first after accept) where wb_valid rises.
    task automatic measure(output int sc, output int wc);
        sc = 0;
        wc = -1;
        for (int c = 1; c <= 40; c++) begin
            if (fpu_sel) sc++;
            if (wb_valid) begin
                wc = c;
                break;
            end
            tick();
        end
    endtask

    initial begin
        clear = 1'b1; flush = 1'b0; issue_valid = 1'b0; wb_ready = 1'b0;
        issue_op = 4'd0; issue_func3 = 3'd0; issue_rs1_0 = 1'b0;
        issue_a = 32'h0; issue_b = 32'h0; issue_rd = 5'd0;
        tick(); tick();
        clear = 1'b0;
        #1;
        check("rst_sel", fpu_sel, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_illegal", wb_illegal, 0);
        check("rst_to_int", wb_to_int, 0);
        check("rst_op", fpu_op, 0);
        check("rst_dataA", fpu_dataA, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_issue_ready", issue_ready, 1);

        // FADD, LAT 7
        issue(4'h0, 32'h3F800000, 32'h40000000, 5'd5, 7, 32'h40400000);
        check("fadd_busy_c1", busy, 1);
        check("fadd_ready_c1", issue_ready, 0);
        measure(sel_cnt, wv_cyc);
        check("fadd_sel_cycles", sel_cnt, 8);
        check("fadd_wv_cycle", wv_cyc, 9);
        check("fadd_data", wb_data, 32'h40400000);
        check("fadd_to_int", wb_to_int, 0);
        check("fadd_rd", wb_rd, 5);
        check("fadd_dataB_held", fpu_dataB, 32'h40000000);
        check("fadd_func3", fpu_func3, 1);
        wb_ready = 1'b1;
        tick();
        check("fadd_idle", busy, 0);
        check("fadd_wv_drop", wb_valid, 0);
        wb_ready = 1'b0;

        // FSGNJ, LAT 0
        issue(4'h4, 32'h1, 32'h2, 5'd6, 0, 32'h11112222);
        measure(sel_cnt, wv_cyc);
        check("sgnj_sel_cycles", sel_cnt, 1);
        check("sgnj_wv_cycle", wv_cyc, 2);
        check("sgnj_data", wb_data, 32'h11112222);
        wb_ready = 1'b1;
        tick();

        // FMUL then FEQ back-to-back with wb_ready held high
        issue(4'h2, 32'h40400000, 32'h40000000, 5'd7, 5, 32'hAAAA5555);
        measure(sel_cnt, wv_cyc);
        check("fmul_sel_cycles", sel_cnt, 6);
        check("fmul_wv_cycle", wv_cyc, 7);
        check("fmul_data", wb_data, 32'hAAAA5555);
        check("fmul_done_ready", issue_ready, 1);
        issue(4'h7, 32'h3F800000, 32'h3F800000, 5'd9, 1, 32'h00000001);
        check("b2b_no_bubble_sel", fpu_sel, 1);
        check("b2b_wv_low", wb_valid, 0);
        measure(sel_cnt, wv_cyc);
        check("feq_sel_cycles", sel_cnt, 2);
        check("feq_wv_cycle", wv_cyc, 3);
        check("feq_to_int", wb_to_int, 1);
        check("feq_data", wb_data, 1);
        check("feq_rd", wb_rd, 9);
        tick();
        check("feq_popped", wb_valid, 0);
        wb_ready = 1'b0;

        // FCVT.W: integer target
        issue(4'h8, 32'h40A00000, 32'h0, 5'd10, 6, 32'h00000005);
        measure(sel_cnt, wv_cyc);
        check("fcvt_sel_cycles", sel_cnt, 7);
        check("fcvt_to_int", wb_to_int, 1);
        check("fcvt_data", wb_data, 5);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;

        // FSQRT with writeback stalled for 10 cycles
        issue(4'h6, 32'h3F000000, 32'h0, 5'd11, 16, 32'h3F3504F3);
        check("sqrt_to_int_cleared", wb_to_int, 0);
        measure(sel_cnt, wv_cyc);
        check("sqrt_sel_cycles", sel_cnt, 17);
        check("sqrt_wv_cycle", wv_cyc, 18);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_wv", wb_valid, 1);
            check("bp_data", wb_data, 32'h3F3504F3);
            check("bp_ready", issue_ready, 0);
            check("bp_busy", busy, 1);
        end
        wb_ready = 1'b1;
        #1;
        check("bp_release_ready", issue_ready, 1);
        tick();
        check("bp_idle", busy, 0);
        wb_ready = 1'b0;

        // Flush in BUSY cycle 3 of FDIV, with a competing issue
        issue(4'h3, 32'h40C00000, 32'h40000000, 5'd12, 6, 32'h40400000);
        tick(); tick();
        check("div_c3_sel", fpu_sel, 1);
        flush = 1'b1;
        issue(4'h4, 32'h5, 32'h6, 5'd13, 0, 32'h0);
        flush = 1'b0;
        check("flush_busy_sel", fpu_sel, 0);
        check("flush_busy_busy", busy, 0);
        check("flush_busy_op", fpu_op, 3);
        sel_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (wb_valid || fpu_sel) sel_cnt++;
            tick();
        end
        check("flush_busy_quiet", sel_cnt, 0);

        // Flush in DONE with wb_ready and issue_valid both high
        issue(4'h5, 32'h1, 32'h2, 5'd14, 1, 32'h00000002);
        measure(sel_cnt, wv_cyc);
        check("minmax_wv_cycle", wv_cyc, 3);
        wb_ready = 1'b1;
        flush    = 1'b1;
        #1;
        check("flush_done_ready", issue_ready, 1);
        issue(4'h0, 32'h7, 32'h8, 5'd3, 7, 32'h0);
        flush = 1'b0;
        check("flush_done_wv", wb_valid, 0);
        check("flush_done_sel", fpu_sel, 0);
        check("flush_done_busy", busy, 0);
        check("flush_done_op", fpu_op, 5);
        check("flush_done_rd", wb_rd, 14);
        wb_ready = 1'b0;

        // Illegal op
        issue(4'hF, 32'h12345678, 32'h9, 5'd15, 0, 32'h0);
        check("ill_sel", fpu_sel, 0);
        check("ill_wv", wb_valid, 1);
        check("ill_flag", wb_illegal, 1);
        check("ill_data", wb_data, 0);
        check("ill_to_int", wb_to_int, 0);
        check("ill_rd", wb_rd, 15);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;

        // Clear mid-FSQRT
        issue(4'h6, 32'h40800000, 32'h1, 5'd16, 16, 32'h40000000);
        check("sqrt2_ill_cleared", wb_illegal, 0);
        tick(); tick(); tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_sel", fpu_sel, 0);
        check("clr_busy", busy, 0);
        check("clr_wv", wb_valid, 0);
        check("clr_op", fpu_op, 0);
        check("clr_dataA", fpu_dataA, 0);
        check("clr_dataB", fpu_dataB, 0);
        check("clr_rs1_0", fpu_rs1_0, 0);
        check("clr_rd", wb_rd, 0);
        check("clr_ready", issue_ready, 1);
        tick(); tick();
        check("clr_stays_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
